// File: rtl/lock_detect.sv
// ---------------------------------------------------------------------------
// lock_detect
//
// PLL lock detector driven by a phase-frequency detector (PFD). The PFD
// enable/polarity pair is sampled every clock. Over each fixed window of
// WINDOW cycles, the block counts how many samples showed a phase error
// (enable high). It also counts how many of those asked the VCXO to go up or
// down. At the end of each window it publishes the totals and runs a lock
// state machine with hysteresis:
//   - LOCK_WINDOWS consecutive windows with at most LOCK_THRESH error samples
//     declare lock.
//   - Lock is only dropped when a window exceeds UNLOCK_THRESH.
//
// Ports
//   clock        sampling clock (VCXO domain), rising edge
//   reset_n      synchronous active-low reset
//   pol          PFD polarity, asynchronous; 1 = VCXO must go up
//   enable       PFD enable, asynchronous; 1 = phase error present
//   locked       registered lock indication
//   err_count    error-sample count of the last completed window
//   dir          dominant correction direction of the last window (1 = up)
//   window_done  one-cycle strobe in the cycle the three outputs above update
// ---------------------------------------------------------------------------
module lock_detect #(
  parameter int unsigned WINDOW        = 4096,
  parameter int unsigned LOCK_THRESH   = 8,
  parameter int unsigned UNLOCK_THRESH = 64,
  parameter int unsigned LOCK_WINDOWS  = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      pol,
  input  logic                      enable,
  output logic                      locked,
  output logic [$clog2(WINDOW):0]   err_count,
  output logic                      dir,
  output logic                      window_done
);

  // Accumulator width holds a full window of samples (WINDOW itself).
  localparam int unsigned CW  = $clog2(WINDOW) + 1;
  localparam int unsigned WCW = $clog2(WINDOW);
  localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW - 1);

  typedef enum logic [1:0] {
    S_UNLOCKED,
    S_ACQUIRE,
    S_LOCKED
  } state_t;

  // Two-flop synchronizers for the asynchronous PFD outputs
  logic en_meta_q,  en_meta_d;
  logic en_sync_q,  en_sync_d;
  logic pol_meta_q, pol_meta_d;
  logic pol_sync_q, pol_sync_d;

  // Window position and per-window accumulators
  logic [WCW-1:0] win_cnt_q, win_cnt_d;
  logic [CW-1:0]  err_acc_q, err_acc_d;
  logic [CW-1:0]  up_acc_q,  up_acc_d;
  logic [CW-1:0]  dn_acc_q,  dn_acc_d;

  // Published results and lock FSM
  logic [CW-1:0]  err_count_q, err_count_d;
  logic           dir_q, dir_d;
  logic           window_done_q, window_done_d;
  logic           locked_q, locked_d;
  state_t         state_q, state_d;
  logic [7:0]     good_cnt_q, good_cnt_d;

  // Combinational helpers
  logic           win_last;
  logic           smp_err, smp_up, smp_dn;
  logic [CW-1:0]  err_fin, up_fin, dn_fin;
  logic [7:0]     good_inc;
  logic           good_win, bad_acq, bad_lock;

  // Saturating increment: an accumulator pinned at all-ones stays there.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] a, input logic b);
    return (b && (a != '1)) ? a + CW'(1) : a;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    en_meta_d     = enable;
    en_sync_d     = en_meta_q;
    pol_meta_d    = pol;
    pol_sync_d    = pol_meta_q;

    smp_err       = en_sync_q;
    smp_up        = en_sync_q & pol_sync_q;
    smp_dn        = en_sync_q & ~pol_sync_q;

    // Totals including the current cycle's sample; on the last cycle of a
    // window these are the window's final values.
    err_fin       = sat_inc(err_acc_q, smp_err);
    up_fin        = sat_inc(up_acc_q,  smp_up);
    dn_fin        = sat_inc(dn_acc_q,  smp_dn);

    win_last      = (win_cnt_q == WIN_LAST);

    win_cnt_d     = win_last ? '0 : win_cnt_q + WCW'(1);
    // Clearing on the last cycle lets the first sample of the new window be
    // added on the next edge, so no sample is dropped or counted twice.
    err_acc_d     = win_last ? '0 : err_fin;
    up_acc_d      = win_last ? '0 : up_fin;
    dn_acc_d      = win_last ? '0 : dn_fin;

    err_count_d   = err_count_q;
    dir_d         = dir_q;
    window_done_d = win_last;
    state_d       = state_q;
    good_cnt_d    = good_cnt_q;

    good_inc      = good_cnt_q + 8'd1;
    good_win      = (32'(err_fin) <= LOCK_THRESH);
    bad_acq       = !good_win;
    bad_lock      = (32'(err_fin) > UNLOCK_THRESH);

    if (win_last) begin
      err_count_d = err_fin;
      // A tie keeps the previous direction.
      if (up_fin > dn_fin) begin
        dir_d = 1'b1;
      end else if (dn_fin > up_fin) begin
        dir_d = 1'b0;
      end

      // The FSM sees the window's final count in the same cycle it is
      // published, so locked and window_done move together.
      unique case (state_q)
        S_UNLOCKED: begin
          if (good_win) begin
            good_cnt_d = 8'd1;
            state_d    = (LOCK_WINDOWS <= 1) ? S_LOCKED : S_ACQUIRE;
          end
        end
        S_ACQUIRE: begin
          if (bad_acq) begin
            good_cnt_d = '0;
            state_d    = S_UNLOCKED;
          end else begin
            good_cnt_d = good_inc;
            if (32'(good_inc) >= LOCK_WINDOWS) begin
              state_d = S_LOCKED;
            end
          end
        end
        S_LOCKED: begin
          // Between LOCK_THRESH and UNLOCK_THRESH lock is held (hysteresis).
          if (bad_lock) begin
            good_cnt_d = '0;
            state_d    = S_UNLOCKED;
          end
        end
        default: begin
          good_cnt_d = '0;
          state_d    = S_UNLOCKED;
        end
      endcase
    end

    locked_d = (state_d == S_LOCKED);
  end

  // NOTE: state elements use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      // NOTE: every flop, synchronizers included, clears on reset; a partial
      // window and any stale PFD sample are discarded.
      en_meta_q     <= 1'b0;
      en_sync_q     <= 1'b0;
      pol_meta_q    <= 1'b0;
      pol_sync_q    <= 1'b0;
      win_cnt_q     <= '0;
      err_acc_q     <= '0;
      up_acc_q      <= '0;
      dn_acc_q      <= '0;
      err_count_q   <= '0;
      dir_q         <= 1'b0;
      window_done_q <= 1'b0;
      locked_q      <= 1'b0;
      state_q       <= S_UNLOCKED;
      good_cnt_q    <= '0;
    end else begin
      en_meta_q     <= en_meta_d;
      en_sync_q     <= en_sync_d;
      pol_meta_q    <= pol_meta_d;
      pol_sync_q    <= pol_sync_d;
      win_cnt_q     <= win_cnt_d;
      err_acc_q     <= err_acc_d;
      up_acc_q      <= up_acc_d;
      dn_acc_q      <= dn_acc_d;
      err_count_q   <= err_count_d;
      dir_q         <= dir_d;
      window_done_q <= window_done_d;
      locked_q      <= locked_d;
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
    end
  end

  assign locked      = locked_q;
  assign err_count   = err_count_q;
  assign dir         = dir_q;
  assign window_done = window_done_q;

endmodule
